// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if -- bus bundle for the sprite OAM DMA engine.
//
// Groups the CPU-side request signals, the arbitrated system bus, the bus
// read-return path and the OAM write port. Clock and reset are not part of
// the bundle.
//
// Modports
//   master : the DMA engine's view (consumes cpu_*, bus_data_*; drives bus_*,
//            oam_*, cpu_halt_o, busy_o)
//   slave  : the surrounding system's view (the mirror image)
// ---------------------------------------------------------------------------
interface oam_dma_if;
    // CPU side
    logic        cpu_tick_i;
    logic [15:0] cpu_address_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_write_i;
    logic        cpu_valid_i;
    logic        cpu_halt_o;
    // Arbitrated system bus
    logic [15:0] bus_address_o;
    logic [7:0]  bus_data_o;
    logic        bus_write_o;
    logic        bus_valid_o;
    // System bus read return
    logic [7:0]  bus_data_i;
    logic        bus_data_valid_i;
    // Sprite OAM write port
    logic [7:0]  oam_address_o;
    logic [7:0]  oam_data_o;
    logic        oam_write_o;
    // Status
    logic        busy_o;

    modport master (
        input  cpu_tick_i, cpu_address_i, cpu_data_i, cpu_write_i, cpu_valid_i,
        input  bus_data_i, bus_data_valid_i,
        output cpu_halt_o,
        output bus_address_o, bus_data_o, bus_write_o, bus_valid_o,
        output oam_address_o, oam_data_o, oam_write_o,
        output busy_o
    );

    modport slave (
        output cpu_tick_i, cpu_address_i, cpu_data_i, cpu_write_i, cpu_valid_i,
        output bus_data_i, bus_data_valid_i,
        input  cpu_halt_o,
        input  bus_address_o, bus_data_o, bus_write_o, bus_valid_o,
        input  oam_address_o, oam_data_o, oam_write_o,
        input  busy_o
    );
endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite OAM DMA engine.
//
// A CPU write of a page number to DMA_REG_ADDR halts the CPU and copies the
// 256 bytes {page,8'h00}..{page,8'hFF} from the system bus into sprite OAM,
// one read tick plus one write tick per byte. While idle the system bus
// simply mirrors the CPU bus.
//
// Ports
//   clock_i          system clock
//   reset_i          synchronous, active-low reset
//   io (master)      oam_dma_if bundle: cpu_* request + tick, cpu_halt_o,
//                    bus_* arbitrated bus, bus_data_i/bus_data_valid_i read
//                    return, oam_* write port, busy_o
//
// Configuration
//   OAM_DMA_ALIGN_EN  when defined, a DMA whose HALT tick sees parity==1
//                     inserts one extra ALIGN tick before the first read.
//                     When undefined HALT always goes straight to READ.
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
    input  logic      clock_i,
    input  logic      reset_i,
    oam_dma_if.master io
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [7:0]  r_data;
    logic        r_parity;
    logic        r_captured;   // a byte has been latched during the current READ
    logic        r_busy;

    logic        w_trigger;
    logic        w_have_data;

    // DMA trigger: a ticked, valid CPU write to the DMA register
    assign w_trigger = io.cpu_tick_i & io.cpu_valid_i & io.cpu_write_i &
                       (io.cpu_address_i == DMA_REG_ADDR);

    // Data returned on the tick clock itself is good enough to leave READ
    assign w_have_data = r_captured | io.bus_data_valid_i;

    // Transfer sequencer, parity toggle and data latch
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_page     <= 8'h00;
            r_index    <= 8'h00;
            r_data     <= 8'h00;
            r_parity   <= 1'b0;
            r_captured <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (io.cpu_tick_i) begin
                r_parity <= ~r_parity;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_page     <= io.cpu_data_i;
                        r_index    <= 8'h00;
                        r_captured <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (io.cpu_tick_i) begin
`ifdef OAM_DMA_ALIGN_EN
                        // Odd-parity start needs one extra tick to line up
                        r_state <= r_parity ? ST_ALIGN : ST_READ;
`else
                        r_state <= ST_READ;
`endif
                    end
                end
                ST_ALIGN: begin
                    if (io.cpu_tick_i) begin
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Capture on any clock, not only on ticks
                    if (io.bus_data_valid_i) begin
                        r_data     <= io.bus_data_i;
                        r_captured <= 1'b1;
                    end
                    if (io.cpu_tick_i && w_have_data) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (io.cpu_tick_i) begin
                        r_captured <= 1'b0;
                        if (r_index == 8'hFF) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_index <= r_index + 8'd1;
                            r_state <= ST_READ;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus arbitration: CPU passthrough when idle, DMA read address in READ
    always_comb begin
        io.bus_address_o = 16'h0000;
        io.bus_data_o    = 8'h00;
        io.bus_write_o   = 1'b0;
        io.bus_valid_o   = 1'b0;
        if (r_state == ST_IDLE) begin
            io.bus_address_o = io.cpu_address_i;
            io.bus_data_o    = io.cpu_data_i;
            io.bus_write_o   = io.cpu_write_i;
            io.bus_valid_o   = io.cpu_valid_i;
        end else if (r_state == ST_READ) begin
            io.bus_address_o = {r_page, r_index};
            io.bus_valid_o   = 1'b1;
        end else begin
            io.bus_address_o = {r_page, r_index};
        end
    end

    // OAM write strobe is the WRITE-state tick itself, so it is one clock wide
    always_comb begin
        io.oam_address_o = r_index;
        io.oam_data_o    = r_data;
        if (r_state == ST_WRITE) begin
            io.oam_write_o = io.cpu_tick_i;
        end else begin
            io.oam_write_o = 1'b0;
        end
    end

    assign io.cpu_halt_o = r_busy;
    assign io.busy_o     = r_busy;

endmodule
